// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests the I-cache and feeds the IF/ID register,
// hiding miss latency and redirects that arrive while a miss is still outstanding.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             icache_req,
    output logic [31:0]      icache_addr,
    input  logic [31:0]      icache_rdata,
    input  logic             icache_ready,
    output logic [31:0]      instruction_out,
    output logic [31:0]      pc_plus4_out,
    output logic             fetch_stall_out,
    output logic             flush_out,
    output logic [CNT_W-1:0] miss_count
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_MISS  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [31:0]      pc_inc;
    logic             stall;

    assign pc_inc = pc_q + 32'd4;

    // A redirect during an outstanding miss is parked in pend_pc; the miss must still complete.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        miss_cnt_d = miss_cnt_q;
        stall      = 1'b0;
        case (state_q)
            ST_FETCH: begin
                stall = ~icache_ready;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (icache_ready) begin
                    if (pc_write) begin
                        pc_d = pc_inc;
                    end
                end else begin
                    state_d = ST_MISS;
                    if (miss_cnt_q != {CNT_W{1'b1}}) begin
                        miss_cnt_d = miss_cnt_q + CNT_ONE;
                    end
                end
            end
            ST_MISS: begin
                stall = ~icache_ready;
                if (icache_ready) begin
                    state_d = ST_FETCH;
                    if (redirect_valid) begin
                        pc_d = redirect_pc;
                    end else if (pc_write) begin
                        pc_d = pc_inc;
                    end
                end else if (redirect_valid) begin
                    pend_pc_d = redirect_pc;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Stall even in the completion cycle so the stale word never enters IF/ID.
                stall = 1'b1;
                if (icache_ready) begin
                    state_d = ST_FETCH;
                    pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
                end else if (redirect_valid) begin
                    pend_pc_d = redirect_pc;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            pend_pc_q  <= 32'h0000_0000;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign icache_req      = ~reset;
    assign icache_addr     = pc_q;
    assign pc_plus4_out    = pc_inc;
    assign instruction_out = (icache_ready && !reset) ? icache_rdata : 32'h0000_0000;
    assign fetch_stall_out = stall && !reset;
    assign flush_out       = redirect_valid && !reset;
    assign miss_count      = miss_cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a randomized run
// compared against a behavioural fetch model kept here.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam int          CW      = 4;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          pc_write;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          icache_req;
    logic [31:0]   icache_addr;
    logic [31:0]   icache_rdata;
    logic          icache_ready;
    logic [31:0]   instruction_out;
    logic [31:0]   pc_plus4_out;
    logic          fetch_stall_out;
    logic          flush_out;
    logic [CW-1:0] miss_count;

    int errors = 0;
    int checks = 0;

    // Behavioural model: current PC, whether a miss is open, and a redirect target waiting on it.
    logic [31:0] mPc;
    bit          mMissOpen;
    logic [31:0] mPending[$];
    int          mMisses;

    if_fetch_unit #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_rdata(icache_rdata), .icache_ready(icache_ready),
        .instruction_out(instruction_out), .pc_plus4_out(pc_plus4_out),
        .fetch_stall_out(fetch_stall_out), .flush_out(flush_out),
        .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CW-1:0] expCount();
        return (mMisses > CNT_MAX) ? CW'(CNT_MAX) : CW'(mMisses);
    endfunction

    function automatic bit expStall();
        return (mPending.size() != 0) || !icache_ready;
    endfunction

    task automatic modelReset();
        mPc = RST_PC;
        mMissOpen = 1'b0;
        mPending.delete();
        mMisses = 0;
    endtask

    task automatic modelStep();
        if (mPending.size() != 0) begin
            if (icache_ready) begin
                mPc = redirect_valid ? redirect_pc : mPending[0];
                mPending.delete();
                mMissOpen = 1'b0;
            end else if (redirect_valid) begin
                mPending.delete();
                mPending.push_back(redirect_pc);
            end
        end else if (mMissOpen) begin
            if (icache_ready) begin
                mMissOpen = 1'b0;
                if (redirect_valid) mPc = redirect_pc;
                else if (pc_write) mPc = mPc + 32'd4;
            end else if (redirect_valid) begin
                mPending.push_back(redirect_pc);
            end
        end else begin
            if (redirect_valid) mPc = redirect_pc;
            else if (icache_ready) begin
                if (pc_write) mPc = mPc + 32'd4;
            end else begin
                mMissOpen = 1'b1;
                mMisses++;
            end
        end
    endtask

    task automatic applyStimulus(input bit rdy, input logic [31:0] rdata, input bit pcw,
                                 input bit rv, input logic [31:0] rpc);
        icache_ready   = rdy;
        icache_rdata   = rdata;
        pc_write       = pcw;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #2;
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic runHits(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0);
            tick();
        end
    endtask

    task automatic test_reset();
        applyReset();
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h0000_0080);
        reset = 1'b1;
        #1;
        checks++; if (icache_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %b expected 0", icache_req); end
        checks++; if (instruction_out !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr: got %h expected 0", instruction_out); end
        checks++; if (flush_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_flush: got %b expected 0", flush_out); end
        applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        checks++; if (fetch_stall_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall: got %b expected 0", fetch_stall_out); end
        @(posedge clk);
        #1;
        checks++; if (icache_addr !== RST_PC) begin errors++; $display("[TB] FAIL rst_addr: got %h expected %h", icache_addr, RST_PC); end
        checks++; if (miss_count !== '0) begin errors++; $display("[TB] FAIL rst_cnt: got %0d expected 0", miss_count); end
        reset = 1'b0;
        modelReset();
        applyStimulus(1'b1, 32'h0000_00AA, 1'b1, 1'b0, 32'h0);
        checks++; if (icache_req !== 1'b1) begin errors++; $display("[TB] FAIL rst_req_after: got %b expected 1", icache_req); end
        checks++; if (instruction_out !== 32'h0000_00AA) begin errors++; $display("[TB] FAIL rst_instr_after: got %h expected 000000aa", instruction_out); end
        tick();
    endtask

    task automatic test_sequential();
        applyReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h1000 + i, 1'b1, 1'b0, 32'h0);
            checks++; if (icache_addr !== 32'(4 * i)) begin errors++; $display("[TB] FAIL seq_addr: got %h expected %h", icache_addr, 32'(4 * i)); end
            checks++; if (pc_plus4_out !== 32'(4 * i + 4)) begin errors++; $display("[TB] FAIL seq_plus4: got %h expected %h", pc_plus4_out, 32'(4 * i + 4)); end
            checks++; if (fetch_stall_out !== 1'b0) begin errors++; $display("[TB] FAIL seq_stall: got %b expected 0", fetch_stall_out); end
            checks++; if (miss_count !== '0) begin errors++; $display("[TB] FAIL seq_cnt: got %0d expected 0", miss_count); end
            tick();
        end
    endtask

    task automatic test_miss();
        applyReset();
        runHits(2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'hBAD0_0000, 1'b1, 1'b0, 32'h0);
            checks++; if (icache_addr !== 32'h8) begin errors++; $display("[TB] FAIL miss_addr: got %h expected 00000008", icache_addr); end
            checks++; if (fetch_stall_out !== 1'b1) begin errors++; $display("[TB] FAIL miss_stall: got %b expected 1", fetch_stall_out); end
            checks++; if (instruction_out !== 32'h0) begin errors++; $display("[TB] FAIL miss_nop: got %h expected 0", instruction_out); end
            tick();
        end
        applyStimulus(1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
        checks++; if (fetch_stall_out !== 1'b0) begin errors++; $display("[TB] FAIL miss_done_stall: got %b expected 0", fetch_stall_out); end
        checks++; if (instruction_out !== 32'h1234_5678) begin errors++; $display("[TB] FAIL miss_done_instr: got %h expected 12345678", instruction_out); end
        tick();
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (icache_addr !== 32'hC) begin errors++; $display("[TB] FAIL miss_next_addr: got %h expected 0000000c", icache_addr); end
        checks++; if (miss_count !== 4'd1) begin errors++; $display("[TB] FAIL miss_cnt: got %0d expected 1", miss_count); end
        tick();
    endtask

    task automatic test_hold();
        applyReset();
        runHits(1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h0000_0033, (i == 2), 1'b0, 32'h0);
            checks++; if (icache_addr !== 32'h4) begin errors++; $display("[TB] FAIL hold_addr: got %h expected 00000004", icache_addr); end
            checks++; if (fetch_stall_out !== 1'b0) begin errors++; $display("[TB] FAIL hold_stall: got %b expected 0", fetch_stall_out); end
            tick();
        end
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (icache_addr !== 32'h8) begin errors++; $display("[TB] FAIL hold_advance: got %h expected 00000008", icache_addr); end
        tick();
    endtask

    task automatic test_redirect_fetch();
        applyReset();
        runHits(4);
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b1, 32'h0000_0100);
        checks++; if (flush_out !== 1'b1) begin errors++; $display("[TB] FAIL redir_flush: got %b expected 1", flush_out); end
        checks++; if (icache_addr !== 32'h10) begin errors++; $display("[TB] FAIL redir_addr: got %h expected 00000010", icache_addr); end
        tick();
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (icache_addr !== 32'h100) begin errors++; $display("[TB] FAIL redir_target: got %h expected 00000100", icache_addr); end
        checks++; if (flush_out !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush_clear: got %b expected 0", flush_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        bit          rdyT[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bit          rvT[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] rpcT[5] = '{32'h0, 32'h200, 32'h300, 32'h0, 32'h0};
        applyReset();
        runHits(8);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(rdyT[i], 32'h5A1E_0000, 1'b1, rvT[i], rpcT[i]);
            checks++; if (icache_addr !== 32'h20) begin errors++; $display("[TB] FAIL b2b_addr[%0d]: got %h expected 00000020", i, icache_addr); end
            checks++; if (fetch_stall_out !== 1'b1) begin errors++; $display("[TB] FAIL b2b_stall[%0d]: got %b expected 1", i, fetch_stall_out); end
            checks++; if (flush_out !== rvT[i]) begin errors++; $display("[TB] FAIL b2b_flush[%0d]: got %b expected %b", i, flush_out, rvT[i]); end
            tick();
        end
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (icache_addr !== 32'h300) begin errors++; $display("[TB] FAIL b2b_target: got %h expected 00000300", icache_addr); end
        checks++; if (fetch_stall_out !== 1'b0) begin errors++; $display("[TB] FAIL b2b_resume_stall: got %b expected 0", fetch_stall_out); end
        tick();
    endtask

    task automatic test_reset_mid_miss();
        applyReset();
        runHits(16);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        applyStimulus(1'b1, 32'h7777_7777, 1'b1, 1'b1, 32'h0000_0500);
        reset = 1'b1;
        #1;
        checks++; if ({icache_req, fetch_stall_out, flush_out} !== 3'b000) begin errors++; $display("[TB] FAIL midrst_ctl: got %b expected 000", {icache_req, fetch_stall_out, flush_out}); end
        checks++; if (instruction_out !== 32'h0) begin errors++; $display("[TB] FAIL midrst_instr: got %h expected 0", instruction_out); end
        checks++; if (icache_addr !== RST_PC) begin errors++; $display("[TB] FAIL midrst_addr: got %h expected %h", icache_addr, RST_PC); end
        checks++; if (miss_count !== '0) begin errors++; $display("[TB] FAIL midrst_cnt: got %0d expected 0", miss_count); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (fetch_stall_out !== 1'b0) begin errors++; $display("[TB] FAIL midrst_resume_stall: got %b expected 0", fetch_stall_out); end
        tick();
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        checks++; if (icache_addr !== RST_PC + 32'd4) begin errors++; $display("[TB] FAIL midrst_fetch: got %h expected %h", icache_addr, RST_PC + 32'd4); end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] d;
        applyReset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            d = $urandom;
            applyStimulus($urandom_range(0, 9) < 6, d, $urandom_range(0, 9) < 8,
                          $urandom_range(0, 9) == 0, r & 32'hFFFF_FFFC);
            checks++; if (icache_addr !== mPc) begin errors++; $display("[TB] FAIL rnd_addr @%0d: got %h expected %h", i, icache_addr, mPc); end
            checks++; if (pc_plus4_out !== mPc + 32'd4) begin errors++; $display("[TB] FAIL rnd_plus4 @%0d: got %h expected %h", i, pc_plus4_out, mPc + 32'd4); end
            checks++; if (fetch_stall_out !== expStall()) begin errors++; $display("[TB] FAIL rnd_stall @%0d: got %b expected %b", i, fetch_stall_out, expStall()); end
            checks++; if (flush_out !== redirect_valid) begin errors++; $display("[TB] FAIL rnd_flush @%0d: got %b expected %b", i, flush_out, redirect_valid); end
            checks++; if (instruction_out !== (icache_ready ? d : 32'h0)) begin errors++; $display("[TB] FAIL rnd_instr @%0d: got %h expected %h", i, instruction_out, icache_ready ? d : 32'h0); end
            checks++; if (miss_count !== expCount()) begin errors++; $display("[TB] FAIL rnd_cnt @%0d: got %0d expected %0d", i, miss_count, expCount()); end
            checks++; if (icache_req !== 1'b1) begin errors++; $display("[TB] FAIL rnd_req @%0d: got %b expected 1", i, icache_req); end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        pc_write = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        icache_rdata = 32'h0;
        icache_ready = 1'b1;
        modelReset();
        test_reset();
        test_sequential();
        test_miss();
        test_hold();
        test_redirect_fetch();
        test_back_to_back();
        test_reset_mid_miss();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
